// File: rtl/ps_fetch_if.sv
// ps_fetch_if: PM read port plus decode valid/ready handshake of the fetch unit.
interface ps_fetch_if #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32
);
  logic                ps_pm_cslt;
  logic                ps_pm_wrb;
  logic [PMA_SIZE-1:0] ps_pm_add;
  logic [PMD_SIZE-1:0] pm_ps_op;
  logic                fch_dec_valid;
  logic                dec_fch_ready;
  logic [PMD_SIZE-1:0] fch_dec_inst;
  logic [PMA_SIZE-1:0] fch_dec_pc;
  modport master (
    output ps_pm_cslt, ps_pm_wrb, ps_pm_add, fch_dec_valid, fch_dec_inst, fch_dec_pc,
    input  pm_ps_op, dec_fch_ready
  );
  modport slave (
    input  ps_pm_cslt, ps_pm_wrb, ps_pm_add, fch_dec_valid, fch_dec_inst, fch_dec_pc,
    output pm_ps_op, dec_fch_ready
  );
endinterface

// File: rtl/ps_fetch.sv
// ps_fetch: sequential PM fetch with 2-entry decode FIFO and jump redirect.
// Define FETCH_CNT_EN to add the fch_cnt pop counter output.
module ps_fetch #(
  parameter int                  PMA_SIZE  = 16,
  parameter int                  PMD_SIZE  = 32,
  parameter logic [PMA_SIZE-1:0] RESET_ADD = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fch_en,
  input  logic                ex_fch_jmp,
  input  logic [PMA_SIZE-1:0] ex_fch_jmp_add,
  ps_fetch_if.master          bus
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]         fch_cnt
`endif
);
  typedef enum logic {IDLE, FETCH} state_t;
  state_t                       state, state_nxt;
  logic [PMA_SIZE-1:0]          pc, rq_pc;
  logic                         rq_v;
  logic [1:0]                   cnt;
  logic                         wr_ptr, rd_ptr;
  logic [PMA_SIZE+PMD_SIZE-1:0] mem [2];
  logic                         pop, push, issue;
  logic [2:0]                   occ;
  assign pop               = bus.fch_dec_valid & bus.dec_fch_ready;
  assign push              = rq_v & ~ex_fch_jmp;
  assign bus.fch_dec_valid = cnt != 2'd0;
  assign {bus.fch_dec_pc, bus.fch_dec_inst} = mem[rd_ptr];
  assign bus.ps_pm_add     = pc;
  assign bus.ps_pm_wrb     = 1'b0;
  assign bus.ps_pm_cslt    = issue;
  // Credit: an in-flight word always has a FIFO slot, counting a same-cycle pop.
  always_comb begin
    state_nxt = fch_en ? FETCH : IDLE;
    occ       = {1'b0, cnt} + {2'b0, rq_v};
    issue     = (state == FETCH) && !ex_fch_jmp && (occ < 3'd2 + {2'b0, pop});
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_ADD;
      rq_pc  <= '0;
      rq_v   <= 1'b0;
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_nxt;
      rq_v  <= issue;
      if (issue) begin
        pc    <= pc + PMA_SIZE'(1);
        rq_pc <= pc;
      end
      if (ex_fch_jmp) begin
        pc     <= ex_fch_jmp_add;
        cnt    <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= {rq_pc, bus.pm_ps_op};
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
    end
`ifdef FETCH_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) fch_cnt <= '0;
    else if (pop) fch_cnt <= fch_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_ps_fetch.sv
// tb_ps_fetch: cycle table, directed corner cases and a randomized stream-order model for ps_fetch.
`timescale 1ns/1ps
module tb_ps_fetch;
  localparam int AW = 16, DW = 32;
  logic          clk = 1'b0, reset = 1'b0;
  logic          fch_en = 1'b0, ex_fch_jmp = 1'b0;
  logic [AW-1:0] ex_fch_jmp_add = '0;
  logic          fch_en2 = 1'b0, ex_fch_jmp2 = 1'b0;
  logic [3:0]    ex_fch_jmp_add2 = '0;
  int            n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ps_fetch_if #(.PMA_SIZE(AW), .PMD_SIZE(DW)) bus ();
  ps_fetch_if #(.PMA_SIZE(4), .PMD_SIZE(DW)) bus2 ();
`ifdef FETCH_CNT_EN
  logic [31:0] fch_cnt, fch_cnt2;
`endif
  ps_fetch #(.PMA_SIZE(AW), .PMD_SIZE(DW), .RESET_ADD(16'h0)) dut (
    .clk(clk), .reset(reset), .fch_en(fch_en), .ex_fch_jmp(ex_fch_jmp),
    .ex_fch_jmp_add(ex_fch_jmp_add), .bus(bus.master)
`ifdef FETCH_CNT_EN
    , .fch_cnt(fch_cnt)
`endif
  );
  ps_fetch #(.PMA_SIZE(4), .PMD_SIZE(DW), .RESET_ADD(4'hE)) dut2 (
    .clk(clk), .reset(reset), .fch_en(fch_en2), .ex_fch_jmp(ex_fch_jmp2),
    .ex_fch_jmp_add(ex_fch_jmp_add2), .bus(bus2.master)
`ifdef FETCH_CNT_EN
    , .fch_cnt(fch_cnt2)
`endif
  );
  function automatic logic [31:0] pm_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction
  // Program memory: registered read, garbage when not selected.
  always @(posedge clk) begin
    bus.pm_ps_op  <= bus.ps_pm_cslt ? pm_word(bus.ps_pm_add) : 32'hDEADBEEF;
    bus2.pm_ps_op <= bus2.ps_pm_cslt ? pm_word({12'h0, bus2.ps_pm_add}) : 32'hDEADBEEF;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    fch_en = 1'b0;
    ex_fch_jmp = 1'b0;
    bus.dec_fch_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask
  typedef struct {
    logic en, rdy, jmp;
    logic [15:0] jadd;
    logic v;
    logic [15:0] pc;
    logic cs;
    logic [15:0] add;
  } vec_t;
  function automatic vec_t mk(input logic en, rdy, jmp, input logic [15:0] jadd,
                              input logic v, input logic [15:0] pc, input logic cs, input logic [15:0] add);
    vec_t r;
    r.en = en; r.rdy = rdy; r.jmp = jmp; r.jadd = jadd;
    r.v = v; r.pc = pc; r.cs = cs; r.add = add;
    return r;
  endfunction
  vec_t tbl [23];
  initial begin
    logic [15:0] exp_pc;
    logic [3:0]  wexp [4];
    int          npop, got;
    bus.dec_fch_ready = 1'b0;
    bus2.dec_fch_ready = 1'b0;
    tbl[0]  = mk(0,0,0,16'h0,  0,16'h0, 0,16'h0);
    tbl[1]  = mk(0,0,0,16'h0,  0,16'h0, 0,16'h0);
    tbl[2]  = mk(1,0,0,16'h0,  0,16'h0, 0,16'h0);
    tbl[3]  = mk(1,0,0,16'h0,  0,16'h0, 1,16'h0);
    tbl[4]  = mk(1,0,0,16'h0,  0,16'h0, 1,16'h1);
    tbl[5]  = mk(1,0,0,16'h0,  1,16'h0, 0,16'h2);
    tbl[6]  = mk(1,0,0,16'h0,  1,16'h0, 0,16'h2);
    tbl[7]  = mk(1,0,0,16'h0,  1,16'h0, 0,16'h2);
    tbl[8]  = mk(1,0,0,16'h0,  1,16'h0, 0,16'h2);
    tbl[9]  = mk(1,0,0,16'h0,  1,16'h0, 0,16'h2);
    tbl[10] = mk(1,0,0,16'h0,  1,16'h0, 0,16'h2);
    tbl[11] = mk(1,1,0,16'h0,  1,16'h0, 1,16'h2);
    tbl[12] = mk(1,1,0,16'h0,  1,16'h1, 1,16'h3);
    tbl[13] = mk(1,1,0,16'h0,  1,16'h2, 1,16'h4);
    tbl[14] = mk(1,1,0,16'h0,  1,16'h3, 1,16'h5);
    tbl[15] = mk(1,1,1,16'h40, 1,16'h4, 0,16'h6);
    tbl[16] = mk(1,1,0,16'h0,  0,16'h0, 1,16'h40);
    tbl[17] = mk(1,1,0,16'h0,  0,16'h0, 1,16'h41);
    tbl[18] = mk(1,1,0,16'h0,  1,16'h40,1,16'h42);
    tbl[19] = mk(0,1,0,16'h0,  1,16'h41,1,16'h43);
    tbl[20] = mk(0,1,0,16'h0,  1,16'h42,0,16'h44);
    tbl[21] = mk(0,1,0,16'h0,  1,16'h43,0,16'h44);
    tbl[22] = mk(0,1,0,16'h0,  0,16'h0, 0,16'h44);
    do_reset();
    chk("rst_valid", bus.fch_dec_valid, 0);
    chk("rst_cslt", bus.ps_pm_cslt, 0);
    chk("rst_add", bus.ps_pm_add, 0);
    chk("rst_inst", bus.fch_dec_inst, 0);
    chk("rst_pc", bus.fch_dec_pc, 0);
    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1 fch_en = tbl[i].en;
      bus.dec_fch_ready = tbl[i].rdy;
      ex_fch_jmp = tbl[i].jmp;
      ex_fch_jmp_add = tbl[i].jadd;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), bus.fch_dec_valid, tbl[i].v);
      chk($sformatf("tbl%0d_cslt", i), bus.ps_pm_cslt, tbl[i].cs);
      chk($sformatf("tbl%0d_add", i), bus.ps_pm_add, tbl[i].add);
      chk($sformatf("tbl%0d_wrb", i), bus.ps_pm_wrb, 0);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), bus.fch_dec_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), bus.fch_dec_inst, pm_word(tbl[i].pc));
      end
    end
    ex_fch_jmp = 1'b0;
    // Async reset in the middle of a stream.
    @(posedge clk);
    #1 fch_en = 1'b1;
    bus.dec_fch_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("mid_pre_valid", bus.fch_dec_valid, 1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_valid", bus.fch_dec_valid, 0);
    chk("mid_rst_cslt", bus.ps_pm_cslt, 0);
    chk("mid_rst_add", bus.ps_pm_add, 0);
    chk("mid_rst_inst", bus.fch_dec_inst, 0);
    chk("mid_rst_pc", bus.fch_dec_pc, 0);
`ifdef FETCH_CNT_EN
    chk("mid_rst_cnt", fch_cnt, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    npop = 0;
    for (int c = 0; c < 40 && npop < 10; c++) begin
      @(negedge clk);
      if (bus.fch_dec_valid && bus.dec_fch_ready) begin
        chk("post_rst_pc", bus.fch_dec_pc, 16'(npop));
        npop++;
      end
      if (npop < 10) @(posedge clk);
    end
    chk("post_rst_pops", npop, 10);
    @(posedge clk);
    #1 bus.dec_fch_ready = 1'b0;
    @(negedge clk);
`ifdef FETCH_CNT_EN
    chk("cnt_after_10", fch_cnt, 10);
`endif
    // Random traffic: accepted words must be consecutive addresses, restarting at each jump target.
    do_reset();
    exp_pc = 16'h0;
    npop = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 fch_en = ($urandom % 8) != 0;
      bus.dec_fch_ready = ($urandom % 4) != 0;
      ex_fch_jmp = ($urandom % 32) == 0;
      ex_fch_jmp_add = 16'($urandom);
      @(negedge clk);
`ifdef FETCH_CNT_EN
      chk("rand_cnt", fch_cnt, 32'(npop));
`endif
      if (bus.ps_pm_wrb !== 1'b0) chk("rand_wrb", bus.ps_pm_wrb, 0);
      if (bus.fch_dec_valid && bus.dec_fch_ready) begin
        chk("rand_pc", bus.fch_dec_pc, exp_pc);
        chk("rand_inst", bus.fch_dec_inst, pm_word(exp_pc));
        exp_pc = exp_pc + 16'd1;
        npop++;
      end
      if (ex_fch_jmp) exp_pc = ex_fch_jmp_add;
    end
    chk("rand_progress", npop > 500, 1);
    @(posedge clk);
    #1 ex_fch_jmp = 1'b0;
    fch_en = 1'b0;
    // Address wrap on a narrow instance starting at 0xE.
    wexp[0] = 4'hE; wexp[1] = 4'hF; wexp[2] = 4'h0; wexp[3] = 4'h1;
    got = 0;
    fch_en2 = 1'b1;
    bus2.dec_fch_ready = 1'b1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk);
      if (bus2.fch_dec_valid && bus2.dec_fch_ready) begin
        chk($sformatf("wrap_pc%0d", got), bus2.fch_dec_pc, wexp[got]);
        chk($sformatf("wrap_inst%0d", got), bus2.fch_dec_inst, pm_word({12'h0, wexp[got]}));
        got++;
      end
      @(posedge clk);
      #1;
    end
    chk("wrap_count", got, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
